// File: rtl/cpu_trace_uart_tx.sv
// ============================================================================
// cpu_trace_uart_tx
//
// Purpose:
//   Debug trace streamer for the CPU top level. Each executed-instruction
//   strobe captures a snapshot {PC, read_a, read_b} into a small FIFO. The
//   FIFO is drained by an 8N1 UART transmitter that sends one 5-byte packet
//   per snapshot:
//       header (0xA5), PC, read_a, read_b, checksum (PC ^ read_a ^ read_b)
//   The FIFO decouples the CPU clock rate from the baud rate. When the FIFO
//   is full, new snapshots are dropped and counted. The CPU is never stalled.
//
// Parameters:
//   CLK_FREQ    system clock frequency in Hz
//   BAUD        serial bit rate; CLK_FREQ/BAUD clocks per bit (must be >= 2)
//   FIFO_DEPTH  snapshot entries (power of two, >= 2)
//
// Ports:
//   clk          system clock
//   rst          asynchronous, active-high reset
//   trace_valid  single-cycle strobe: capture the current snapshot
//   pc_addr      PC value to record
//   read_a       register port A value to record
//   read_b       register port B value to record
//   HALT_flag    CPU halted (used only when TRACE_HALT_MARK_EN is defined)
//   UART_tx      serial line, idle high
//   tx_busy      high while a frame is in flight or the FIFO holds entries
//   drop_count   saturating count of snapshots lost to a full FIFO
//
// Build option:
//   TRACE_HALT_MARK_EN  when defined, a rising edge on HALT_flag enqueues a
//                       marker packet whose header is 0x5A instead of 0xA5.
//                       The header choice travels as a 25th FIFO bit.
// ============================================================================
module cpu_trace_uart_tx #(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       trace_valid,
    input  logic [7:0] pc_addr,
    input  logic [7:0] read_a,
    input  logic [7:0] read_b,
    input  logic       HALT_flag,
    output logic       UART_tx,
    output logic       tx_busy,
    output logic [7:0] drop_count
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int PTR_W        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

`ifdef TRACE_HALT_MARK_EN
    localparam int         ENTRY_W  = 25;
    localparam logic [7:0] HDR_HALT = 8'h5A;
`else
    localparam int         ENTRY_W  = 24;
`endif
    localparam logic [7:0] HDR_TRACE = 8'hA5;

    localparam logic [BAUD_W-1:0] BIT_LAST   = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [PTR_W:0]    FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    // ------------------------------------------------------------------
    // Snapshot FIFO storage and bookkeeping
    // ------------------------------------------------------------------
    logic [ENTRY_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wrPtr;
    logic [PTR_W-1:0]   r_rdPtr;
    logic [PTR_W:0]     r_count;

    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic [ENTRY_W-1:0] w_pushData;
    logic [1:0]         w_dropInc;

    // Transmitter state
    state_t             r_state;
    state_t             w_stateNext;
    logic [BAUD_W-1:0]  r_baudCnt;
    logic [BAUD_W-1:0]  w_baudCntNext;
    logic [2:0]         r_bitIdx;
    logic [2:0]         w_bitIdxNext;
    logic [2:0]         r_byteIdx;
    logic [2:0]         w_byteIdxNext;
    logic               r_tx;
    logic               w_txNext;
    logic [ENTRY_W-1:0] r_frame;
    logic [7:0]         w_header;
    logic [7:0]         w_curByte;
    logic               w_bitDone;

    logic [7:0]         r_dropCount;
    logic [8:0]         w_dropSum;

    // Full is judged on the registered occupancy, so a pop in the same
    // cycle never makes room for a push that arrives with a full FIFO.
    assign w_full  = (r_count == FULL_COUNT);
    assign w_empty = (r_count == '0);

    // ------------------------------------------------------------------
    // Capture: decide what (if anything) is written into the FIFO this
    // cycle, and how many snapshots are lost.
    // ------------------------------------------------------------------
`ifdef TRACE_HALT_MARK_EN
    logic r_haltPrev;
    logic w_haltRise;

    assign w_haltRise = HALT_flag & ~r_haltPrev;

    // Registered copy of HALT_flag for rising-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_haltPrev <= 1'b0;
        end else begin
            r_haltPrev <= HALT_flag;
        end
    end

    // A trace strobe always wins the single write slot; a halt marker that
    // lands on the same cycle is lost and counted like an overflow.
    always_comb begin
        w_push     = 1'b0;
        w_pushData = {1'b0, pc_addr, read_a, read_b};
        w_dropInc  = 2'd0;
        if (trace_valid) begin
            if (w_full) begin
                w_dropInc = 2'd1;
            end else begin
                w_push = 1'b1;
            end
            if (w_haltRise) begin
                w_dropInc = w_dropInc + 2'd1;
            end
        end else if (w_haltRise) begin
            w_pushData = {1'b1, pc_addr, read_a, read_b};
            if (w_full) begin
                w_dropInc = 2'd1;
            end else begin
                w_push = 1'b1;
            end
        end
    end
`else
    // HALT_flag has no role without the marker option.
    logic w_unused;
    assign w_unused = HALT_flag;

    // Only trace strobes write the FIFO; a strobe into a full FIFO is lost.
    always_comb begin
        w_push     = 1'b0;
        w_pushData = {pc_addr, read_a, read_b};
        w_dropInc  = 2'd0;
        if (trace_valid) begin
            if (w_full) begin
                w_dropInc = 2'd1;
            end else begin
                w_push = 1'b1;
            end
        end
    end
`endif

    // FIFO data array. Contents need no reset: the occupancy counter is
    // what defines which slots are valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= w_pushData;
        end
    end

    // FIFO pointers wrap naturally at FIFO_DEPTH (power of two). The
    // occupancy counter is one bit wider so it can represent "full".
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
                2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Lost-snapshot counter; sticks at 255 rather than wrapping so a host
    // can tell "many" from "a few".
    assign w_dropSum = {1'b0, r_dropCount} + {7'd0, w_dropInc};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dropCount <= 8'd0;
        end else if (w_dropSum[8]) begin
            r_dropCount <= 8'hFF;
        end else begin
            r_dropCount <= w_dropSum[7:0];
        end
    end

    // ------------------------------------------------------------------
    // Packet byte selection from the frame register
    // ------------------------------------------------------------------
`ifdef TRACE_HALT_MARK_EN
    assign w_header = r_frame[24] ? HDR_HALT : HDR_TRACE;
`else
    assign w_header = HDR_TRACE;
`endif

    always_comb begin
        w_curByte = w_header;
        case (r_byteIdx)
            3'd0:    w_curByte = w_header;
            3'd1:    w_curByte = r_frame[23:16];
            3'd2:    w_curByte = r_frame[15:8];
            3'd3:    w_curByte = r_frame[7:0];
            default: w_curByte = r_frame[23:16] ^ r_frame[15:8] ^ r_frame[7:0];
        endcase
    end

    assign w_bitDone = (r_baudCnt == BIT_LAST);

    // ------------------------------------------------------------------
    // Transmitter FSM: state, counter and line registers. The serial line
    // is registered so it is glitch-free; it therefore follows the state
    // by one clock, which is why the start bit appears two clocks after
    // the capturing edge.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_baudCnt <= '0;
            r_bitIdx  <= 3'd0;
            r_byteIdx <= 3'd0;
            r_tx      <= 1'b1;
            r_frame   <= '0;
        end else begin
            r_state   <= w_stateNext;
            r_baudCnt <= w_baudCntNext;
            r_bitIdx  <= w_bitIdxNext;
            r_byteIdx <= w_byteIdxNext;
            r_tx      <= w_txNext;
            if (w_pop) begin
                r_frame <= r_mem[r_rdPtr];
            end
        end
    end

    // Transmitter FSM: next-state, counters, FIFO pop and line level.
    // Each bit (start, data, stop) occupies exactly CLKS_PER_BIT clocks;
    // bytes of a packet follow each other with no idle gap, and a new
    // packet can only start from IDLE, giving one idle clock between
    // packets.
    always_comb begin
        w_stateNext   = r_state;
        w_baudCntNext = r_baudCnt;
        w_bitIdxNext  = r_bitIdx;
        w_byteIdxNext = r_byteIdx;
        w_pop         = 1'b0;
        w_txNext      = 1'b1;

        case (r_state)
            S_IDLE: begin
                w_baudCntNext = '0;
                w_bitIdxNext  = 3'd0;
                if (!w_empty) begin
                    w_pop         = 1'b1;
                    w_byteIdxNext = 3'd0;
                    w_stateNext   = S_START;
                end
            end

            S_START: begin
                w_txNext = 1'b0;
                if (w_bitDone) begin
                    w_baudCntNext = '0;
                    w_bitIdxNext  = 3'd0;
                    w_stateNext   = S_DATA;
                end else begin
                    w_baudCntNext = r_baudCnt + BAUD_W'(1);
                end
            end

            S_DATA: begin
                w_txNext = w_curByte[r_bitIdx];
                if (w_bitDone) begin
                    w_baudCntNext = '0;
                    if (r_bitIdx == 3'd7) begin
                        w_stateNext = S_STOP;
                    end else begin
                        w_bitIdxNext = r_bitIdx + 3'd1;
                    end
                end else begin
                    w_baudCntNext = r_baudCnt + BAUD_W'(1);
                end
            end

            S_STOP: begin
                w_txNext = 1'b1;
                if (w_bitDone) begin
                    w_baudCntNext = '0;
                    if (r_byteIdx < 3'd4) begin
                        w_byteIdxNext = r_byteIdx + 3'd1;
                        w_stateNext   = S_START;
                    end else begin
                        w_stateNext = S_IDLE;
                    end
                end else begin
                    w_baudCntNext = r_baudCnt + BAUD_W'(1);
                end
            end

            default: begin
                w_stateNext = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign UART_tx    = r_tx;
    assign tx_busy    = (r_state != S_IDLE) | ~w_empty;
    assign drop_count = r_dropCount;

endmodule
